// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side controller for the synchronous FIFO.
// On a start command it pulls exactly xfer_len words from the FIFO without
// underflowing it. A 2-entry output buffer absorbs the FIFO's one-cycle read
// latency. Words go downstream on a valid/ready stream; completion is a
// one-cycle done pulse, and FIFO underflow is latched into err_underflow.
//
// Optional build macro: DRAIN_STALL_CNT_EN adds the stall_cnt output, a
// saturating count of cycles with m_valid && !m_ready.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, xfer_len     command pulse and word count, sampled together in IDLE
//   busy, done          not-idle flag, completion pulse
//   fifo_empty          FIFO empty flag
//   fifo_underflow      FIFO underflow flag (registered inside the FIFO)
//   fifo_dout           FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en          FIFO read enable
//   m_valid, m_ready    downstream handshake
//   m_data              downstream data (output-buffer head)
//   err_underflow       sticky underflow error
//   stall_cnt           (DRAIN_STALL_CNT_EN only) downstream stall counter
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; no reads issued
// ST_RUN   | issuing FIFO reads until len words have been requested
// ST_FLUSH | all reads issued; draining the buffer until len delivered
module fifo_rd_drain #(
    parameter int FIFO_WIDTH = 16,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      xfer_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  err_underflow
`ifdef DRAIN_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      issued;
    logic [LEN_W-1:0]      delivered;
    logic                  in_flight;
    logic [1:0]            buf_cnt;
    logic [FIFO_WIDTH-1:0] buf0;
    logic [FIFO_WIDTH-1:0] buf1;
    logic                  pop;
    logic                  start_ok;
    logic                  last_pop;
    logic                  done_nx;
    logic [2:0]            occ;

    assign pop      = m_valid && m_ready;
    assign m_valid  = (buf_cnt != 2'd0);
    assign m_data   = buf0;
    assign busy     = (state != ST_IDLE);
    assign start_ok = (state == ST_IDLE) && start && (xfer_len != '0);
    // Occupancy the buffer will have once this cycle's pop and the word
    // already in flight are accounted for; a new read may only go out if
    // there is still room for it.
    assign occ      = {1'b0, buf_cnt} + {2'b00, in_flight} - {2'b00, pop};
    assign last_pop = pop && (delivered == len_q - LEN_W'(1));

    always_comb begin
        state_nx   = state;
        fifo_rd_en = 1'b0;
        done_nx    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (xfer_len != '0) state_nx = ST_RUN;
                    else                done_nx  = 1'b1;
                end
            end
            ST_RUN: begin
                fifo_rd_en = !fifo_empty && (issued < len_q) && (occ < 3'd2);
                if (issued + LEN_W'(fifo_rd_en) == len_q) state_nx = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (last_pop) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            done          <= 1'b0;
            len_q         <= '0;
            issued        <= '0;
            delivered     <= '0;
            in_flight     <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state     <= state_nx;
            done      <= done_nx;
            in_flight <= fifo_rd_en;
            if (start_ok) begin
                len_q         <= xfer_len;
                issued        <= '0;
                delivered     <= '0;
                err_underflow <= 1'b0;
            end else begin
                if (fifo_rd_en) issued <= issued + LEN_W'(1);
                if (pop)        delivered <= delivered + LEN_W'(1);
                if ((state != ST_IDLE) && fifo_underflow) err_underflow <= 1'b1;
            end
        end
    end

    // Two-entry in-order buffer; buf0 is always the head seen downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            case ({in_flight, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) buf0 <= fifo_dout;
                    else                 buf1 <= fifo_dout;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= fifo_dout;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DRAIN_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (start_ok) begin
            stall_cnt <= 16'd0;
        end else if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Testbench for fifo_rd_drain. A queue-based FIFO with one-cycle read latency
// feeds the DUT; the expected output stream is simply the order in which
// words were written, and busy/done/err/stall expectations come from the
// transfer-level rules (start, word counts, handshakes).
module tb_fifo_rd_drain;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  xfer_len;
    logic        busy;
    logic        done;
    logic        fifo_empty;
    logic        fifo_underflow;
    logic [15:0] fifo_dout;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        err_underflow;
`ifdef DRAIN_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fifo_rd_drain #(.FIFO_WIDTH(16), .LEN_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .xfer_len       (xfer_len),
        .busy           (busy),
        .done           (done),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_dout      (fifo_dout),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .err_underflow  (err_underflow)
`ifdef DRAIN_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // source FIFO and expected stream
    logic [15:0] fq[$];
    logic [15:0] exp_words[$];
    logic [15:0] pending_vals[$];
    logic        wr_req   = 1'b0;
    logic [15:0] wr_data  = '0;
    logic        force_uf = 1'b0;
    logic        last_rd  = 1'b0;

    // transfer-level expectations
    logic        busy_exp  = 1'b0;
    logic        done_exp  = 1'b0;
    logic        err_exp   = 1'b0;
    logic [15:0] stall_exp = '0;
    int          len_cur    = 0;
    int          pops_seen  = 0;
    int          reads_seen = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;

    int          cyc = 0;
    int          start_cyc = 0;
    logic        rec_on = 1'b0;
    logic [15:0] rd_mask, val_mask, done_mask, busy_mask;
    int          stall_probe = -1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic        pop;
        logic        busy_nx, done_nx, err_nx;
        logic [15:0] stall_nx;
        int          rel;
        pop = m_valid && m_ready;
        rel = cyc - start_cyc;
        if (rec_on && rel >= 0 && rel < 16) begin
            rd_mask[rel]   = fifo_rd_en;
            val_mask[rel]  = m_valid;
            done_mask[rel] = done;
            busy_mask[rel] = busy;
        end
        check_val("busy", busy, busy_exp);
        check_val("done", done, done_exp);
        check_val("err_underflow", err_underflow, err_exp);
`ifdef DRAIN_STALL_CNT_EN
        check_val("stall_cnt", stall_cnt, stall_exp);
`endif
        if (fifo_rd_en) begin
            check_val("rd_while_empty", fifo_empty, 0);
            check_val("rd_while_idle", busy_exp, 1);
            reads_seen++;
            check_val("rd_over_len", reads_seen <= len_cur, 1);
        end
        if (prev_stall) begin
            check_val("hold_valid", m_valid, 1);
            check_val("hold_data", m_data, prev_data);
        end
        if (pop) begin
            check_val("pop_in_xfer", busy_exp && (pops_seen < len_cur), 1);
            if (exp_words.size() > 0) check_val("m_data", m_data, exp_words.pop_front());
            pops_seen++;
        end
        busy_nx  = busy_exp;
        done_nx  = 1'b0;
        err_nx   = err_exp;
        stall_nx = stall_exp;
        if (busy_exp && fifo_underflow) err_nx = 1'b1;
        if (m_valid && !m_ready && stall_exp != 16'hFFFF) stall_nx = stall_exp + 16'd1;
        if (start && !busy_exp) begin
            len_cur    = int'(xfer_len);
            reads_seen = 0;
            pops_seen  = 0;
            if (xfer_len == 8'd0) begin
                done_nx = 1'b1;
            end else begin
                busy_nx  = 1'b1;
                err_nx   = 1'b0;
                stall_nx = '0;
            end
        end
        if (pop && busy_exp && pops_seen == len_cur) begin
            busy_nx = 1'b0;
            done_nx = 1'b1;
        end
        busy_exp   = busy_nx;
        done_exp   = done_nx;
        err_exp    = err_nx;
        stall_exp  = stall_nx;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        last_rd    = fifo_rd_en;
    endtask

    // One-cycle-latency FIFO: reads and writes requested in cycle t take
    // effect just after the edge that ends t.
    task automatic fifo_update();
        fifo_underflow = force_uf;
        force_uf = 1'b0;
        if (last_rd) begin
            if (fq.size() > 0) fifo_dout = fq.pop_front();
            else               fifo_underflow = 1'b1;
        end
        if (wr_req) begin
            fq.push_back(wr_data);
            exp_words.push_back(wr_data);
            wr_req = 1'b0;
        end
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        cyc++;
        @(posedge clk);
        #1;
        fifo_update();
    endtask

    task automatic preload(input logic [15:0] v);
        fq.push_back(v);
        exp_words.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic run_xfer(input int len, input int to_write, input int rdy_pct,
                            input int wr_pct, input int wr_period, input int stall0,
                            input int uf_at);
        int rel;
        int remaining;
        int budget;
        int stall_left;
        remaining  = to_write;
        stall_left = stall0;
        budget     = 0;
        m_ready    = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
        if (stall_left > 0) stall_left--;
        start      = 1'b1;
        xfer_len   = len[7:0];
        start_cyc  = cyc;
        tick();
        start = 1'b0;
        while ((busy_exp || done_exp) && budget < 3000) begin
            rel = cyc - start_cyc;
            if (rel == stall_probe) begin
                check_val("stall_reads", reads_seen, 2);
                check_val("stall_head", m_data, 16'h00A1);
`ifdef DRAIN_STALL_CNT_EN
                check_val("stall_cnt_10", stall_cnt, 16'd10);
`endif
            end
            m_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (stall_left > 0) stall_left--;
            if (remaining > 0 &&
                ((wr_period > 0) ? (rel >= wr_period + 1 && rel % wr_period == 1)
                                 : ($urandom_range(99) < wr_pct))) begin
                wr_req  = 1'b1;
                wr_data = (pending_vals.size() > 0) ? pending_vals.pop_front()
                                                    : 16'($urandom);
                remaining--;
            end
            if (rel == uf_at) force_uf = 1'b1;
            tick();
            budget++;
        end
        if (budget >= 3000) check_val("xfer_timeout", busy, 0);
        check_val("reads_issued", reads_seen, len);
        check_val("words_left", exp_words.size(), 0);
        m_ready = 1'b0;
    endtask

    initial begin
        int len, pre;
        rst_n          = 1'b0;
        start          = 1'b0;
        xfer_len       = '0;
        fifo_empty     = 1'b1;
        fifo_underflow = 1'b0;
        fifo_dout      = '0;
        m_ready        = 1'b0;
        #3;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_rd_en", fifo_rd_en, 0);
        check_val("rst_valid", m_valid, 0);
        check_val("rst_data", m_data, 0);
        check_val("rst_err", err_underflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // preloaded, m_ready high: fixed latency profile
        for (int i = 1; i <= 4; i++) preload(16'(16'h00A0 + i));
        rd_mask = '0; val_mask = '0; done_mask = '0; busy_mask = '0;
        rec_on = 1'b1;
        run_xfer(4, 0, 100, 0, 0, 0, -1);
        rec_on = 1'b0;
        check_val("lat_rd_mask", rd_mask[8:0], 9'b000011110);
        check_val("lat_valid_mask", val_mask[8:0], 9'b001111000);
        check_val("lat_done_mask", done_mask[8:0], 9'b010000000);
        check_val("lat_busy_mask", busy_mask[8:0], 9'b001111110);
        tick();

        // downstream stalled for 10 valid cycles
        for (int i = 1; i <= 4; i++) preload(16'(16'h00A0 + i));
        stall_probe = 13;
        run_xfer(4, 0, 100, 0, 0, 13, -1);
        stall_probe = -1;
        tick();

        // FIFO starts empty, words trickle in
        pending_vals.push_back(16'h0011);
        pending_vals.push_back(16'h0022);
        pending_vals.push_back(16'h0033);
        run_xfer(3, 3, 100, 0, 4, 0, -1);
        tick();

        // zero-length command
        run_xfer(0, 0, 100, 0, 0, 0, -1);
        tick();

        // injected underflow mid-RUN, sticky through done, cleared by next start
        for (int i = 0; i < 6; i++) preload(16'($urandom));
        run_xfer(6, 0, 100, 0, 0, 0, 2);
        check_val("err_held", err_underflow, 1);
        tick();
        preload(16'h5A5A);
        run_xfer(1, 0, 100, 0, 0, 0, -1);
        tick();

        // reset with one word buffered and one in flight
        for (int i = 1; i <= 4; i++) preload(16'(16'h00B0 + i));
        m_ready   = 1'b0;
        start     = 1'b1;
        xfer_len  = 8'd4;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_val("pre_rst_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_rd_en", fifo_rd_en, 0);
        check_val("midrst_valid", m_valid, 0);
        check_val("midrst_data", m_data, 0);
        check_val("midrst_err", err_underflow, 0);
        busy_exp = 1'b0; done_exp = 1'b0; err_exp = 1'b0; stall_exp = '0;
        prev_stall = 1'b0; last_rd = 1'b0; len_cur = 0;
        fq.delete();
        exp_words.delete();
        fifo_empty = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        for (int i = 1; i <= 3; i++) preload(16'(16'h00C0 + i));
        run_xfer(3, 0, 100, 0, 0, 0, -1);
        tick();

        // randomized transfers
        for (int t = 0; t < 25; t++) begin
            len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 24));
            pre = int'($urandom_range(0, len));
            for (int i = 0; i < pre; i++) preload(16'($urandom));
            run_xfer(len, len - pre, int'($urandom_range(30, 100)),
                     int'($urandom_range(20, 100)), 0, int'($urandom_range(0, 5)),
                     ($urandom_range(3) == 0) ? int'($urandom_range(1, 6)) : -1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side controller for the team's synchronous FIFO; it is the consumer counterpart of the FIFO write port.
- On a start command it pulls exactly xfer_len words out of the FIFO without ever underflowing it.
- It absorbs the FIFO's one-cycle read latency in a 2-entry output buffer.
- It presents the words downstream on a valid/ready stream, reports completion and flags any FIFO underflow.

Parameters:
- FIFO_WIDTH, 16, data word width (matches the FIFO data_out width).
- LEN_W, 8, width of the transfer-length field and of the internal issue/deliver counters.

Ports:
- clk  in  1  clock, all logic on its rising edge.
- rst_n  in  1  reset.
- start  in  1  one-cycle command pulse; honoured only in IDLE.
- xfer_len  in  LEN_W  number of words to drain; sampled with start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the transfer completes.
- fifo_empty  in  1  FIFO empty flag.
- fifo_underflow  in  1  FIFO underflow flag (registered in the FIFO, one cycle after a bad read).
- fifo_dout  in  FIFO_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read enable.
- m_valid  out  1  downstream data valid.
- m_ready  in  1  downstream ready.
- m_data  out  FIFO_WIDTH  downstream data, i.e. the output-buffer head.
- err_underflow  out  1  sticky underflow error.

Interface rule (already decided): one clock; reset is asynchronous and active-low; ports are named clk and rst_n.

Behaviour:
- Reset (rst_n low, asynchronous), all outputs and state cleared:
  - state=IDLE, fifo_rd_en=0, m_valid=0, m_data=0, busy=0, done=0, err_underflow=0.
  - Issue and deliver counters=0, buffer count=0, in_flight=0.
  - Reset mid-transfer discards buffered words; no done pulse is produced.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: start=1 with xfer_len>0 -> RUN; latch len; clear counters and err_underflow.
  - IDLE: start=1 with xfer_len=0 -> stay IDLE; done=1 in the next cycle; no reads issued.
  - RUN: when issued==len after this cycle's read -> FLUSH.
  - FLUSH: when delivered==len (last handshake) -> IDLE; done=1 the cycle after the final m_valid&&m_ready.
  - start in RUN or FLUSH is ignored.
- Read issue (combinational):
  - fifo_rd_en = (state==RUN) && !fifo_empty && (issued<len) && (buf_cnt + in_flight - pop < 2).
  - pop = m_valid && m_ready.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Latency: a read in cycle t loads fifo_dout into the buffer at the end of t+1; m_valid is high from t+2.
  - Throughput with m_ready held high is 1 word/cycle.
- Output buffer: 2-entry FIFO, in-order. m_valid = buf_cnt>0.
  - m_data and m_valid stay stable while m_valid && !m_ready.
  - Simultaneous capture and pop: count unchanged, order preserved.
- Counters: issued and delivered are LEN_W wide and never wrap, since both are bounded by len.
- Underflow: fifo_underflow=1 in any non-IDLE state sets err_underflow.
  - err_underflow holds until the next accepted start or reset.
  - FSM flow is unaffected.
- busy = state!=IDLE. done is never asserted together with busy rising.

Optional Feature:
- Macro: DRAIN_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0]. It increments every cycle m_valid && !m_ready, saturates at 16'hFFFF, is cleared on accepted start and reads 0 after reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- FIFO preloaded 0xA1,0xA2,0xA3,0xA4; start, xfer_len=4; m_ready=1 -> fifo_rd_en high cycles 1-4; m_data 0xA1..0xA4 on cycles 3-6; done=1 cycle 7; busy low cycle 7.
- Same preload, m_ready=0 for 10 cycles then 1 -> exactly 2 reads issued while stalled; m_data=0xA1 held stable; all 4 words delivered in order; (macro on) stall_cnt=10.
- FIFO empty; start, xfer_len=3; write 0x11,0x22,0x33 at cycles 5, 9, 13 -> fifo_rd_en only while !fifo_empty; fifo_underflow never set; 3 words out in order, then done.
- start with xfer_len=0 -> no fifo_rd_en; done=1 next cycle; busy stays 0.
- Force fifo_underflow=1 for one cycle mid-RUN -> err_underflow=1 and held through done; cleared by the next start.
- rst_n low for one cycle with 1 word buffered and 1 in flight -> all outputs 0 immediately; state IDLE; no done pulse; a subsequent start works normally.
